// File: rtl/bandai_eeprom_ctrl_if.sv
// Mapper-side register strobe bus and Microwire pins for the Bandai save EEPROM controller.
interface bandai_eeprom_ctrl_if;
    logic       IO_WE;
    logic [2:0] IO_ADDR;
    logic [7:0] IO_WDATA;
    logic [7:0] IO_RDATA;
    logic       EE_CS;
    logic       EE_SK;
    logic       EE_DI;
    logic       EE_DO;

    modport master (
        output IO_WE, IO_ADDR, IO_WDATA, EE_DO,
        input  IO_RDATA, EE_CS, EE_SK, EE_DI
    );

    modport slave (
        input  IO_WE, IO_ADDR, IO_WDATA, EE_DO,
        output IO_RDATA, EE_CS, EE_SK, EE_DI
    );
endinterface

// File: rtl/bandai_eeprom_ctrl.sv
// 93C46-class (x16) Microwire controller behind console ports C4h-C8h:
// data/command/status registers, command/data framing and post-write ready polling.
module bandai_eeprom_ctrl #(
    parameter int unsigned SK_DIV    = 4,
    parameter int unsigned ADDR_BITS = 6,
    parameter int unsigned POLL_MAX  = 4096
) (
    input logic                 CLK,
    input logic                 RST,
    bandai_eeprom_ctrl_if.slave bus
);
    localparam int unsigned CMD_LEN = ADDR_BITS + 3;
    localparam int unsigned PER     = 2 * SK_DIV;
    localparam int unsigned CNT_MAX = (POLL_MAX > PER) ? POLL_MAX : PER;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = 4;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_DOUT, S_DIN, S_GAP, S_POLL, S_END} state_t;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ERASE, OP_SHORT} op_t;

    state_t             state, state_n;
    op_t                op, op_n, start_op;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [BIT_W-1:0]   bitn, bit_n;
    logic [14:0]        sh, sh_n;
    logic [15:0]        rbuf, rbuf_n;
    logic [15:0]        wdata, cmd;
    logic               done, done_n, timeout, timeout_n;
    logic               cs, cs_n, sk, sk_n, di, di_n;
    logic               do_s1, do_s2;
    logic               idle, start, period_end;
    logic [7:0]         rdata;

    assign idle  = (state == S_IDLE);
    assign start = idle && bus.IO_WE && (bus.IO_ADDR == 3'd4) && (|bus.IO_WDATA[7:4]);

    // Later assignments win: READ > WRITE > ERASE > SHORT.
    always_comb begin
        start_op = OP_SHORT;
        if (bus.IO_WDATA[6]) start_op = OP_ERASE;
        if (bus.IO_WDATA[5]) start_op = OP_WRITE;
        if (bus.IO_WDATA[4]) start_op = OP_READ;
    end

    // Host-visible data and command registers, frozen while a frame is running.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wdata <= '0;
            cmd   <= '0;
        end else if (bus.IO_WE && idle) begin
            case (bus.IO_ADDR)
                3'd0:    wdata[7:0]  <= bus.IO_WDATA;
                3'd1:    wdata[15:8] <= bus.IO_WDATA;
                3'd2:    cmd[7:0]    <= bus.IO_WDATA;
                3'd3:    cmd[15:8]   <= bus.IO_WDATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            op      <= OP_READ;
            cnt     <= '0;
            bitn    <= '0;
            sh      <= '0;
            rbuf    <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
            cs      <= 1'b0;
            sk      <= 1'b0;
            di      <= 1'b0;
            do_s1   <= 1'b0;
            do_s2   <= 1'b0;
        end else begin
            state   <= state_n;
            op      <= op_n;
            cnt     <= cnt_n;
            bitn    <= bit_n;
            sh      <= sh_n;
            rbuf    <= rbuf_n;
            done    <= done_n;
            timeout <= timeout_n;
            cs      <= cs_n;
            sk      <= sk_n;
            di      <= di_n;
            do_s1   <= bus.EE_DO;
            do_s2   <= do_s1;
        end
    end

    // Counters restart on every state change; pin values are derived from the next state.
    always_comb begin
        state_n    = state;
        op_n       = op;
        cnt_n      = cnt + CNT_W'(1);
        bit_n      = bitn;
        sh_n       = sh;
        rbuf_n     = rbuf;
        done_n     = done;
        timeout_n  = timeout;
        cs_n       = 1'b0;
        sk_n       = 1'b0;
        di_n       = 1'b0;
        period_end = (cnt == CNT_W'(PER - 1));

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (start) begin
                    op_n      = start_op;
                    done_n    = 1'b0;
                    timeout_n = 1'b0;
                    state_n   = S_CMD;
                end
            end
            S_CMD: if (period_end) begin
                cnt_n = '0;
                if (bitn == BIT_W'(CMD_LEN - 1)) begin
                    bit_n = '0;
                    case (op)
                        OP_READ:  state_n = S_DIN;
                        OP_WRITE: state_n = S_DOUT;
                        OP_ERASE: state_n = S_GAP;
                        default:  state_n = S_END;
                    endcase
                end else begin
                    bit_n = bitn + BIT_W'(1);
                end
            end
            S_DOUT: if (period_end) begin
                cnt_n = '0;
                if (bitn == BIT_W'(15)) begin
                    bit_n   = '0;
                    state_n = S_GAP;
                end else begin
                    bit_n = bitn + BIT_W'(1);
                end
            end
            S_DIN: if (period_end) begin
                cnt_n = '0;
                sh_n  = {sh[13:0], do_s2};
                if (bitn == BIT_W'(15)) begin
                    bit_n   = '0;
                    rbuf_n  = {sh, do_s2};
                    state_n = S_END;
                end else begin
                    bit_n = bitn + BIT_W'(1);
                end
            end
            S_GAP: if (period_end) begin
                cnt_n   = '0;
                state_n = S_POLL;
            end
            S_POLL: begin
                if (do_s2) begin
                    cnt_n   = '0;
                    state_n = S_END;
                end else if (cnt == CNT_W'(POLL_MAX - 1)) begin
                    cnt_n     = '0;
                    timeout_n = 1'b1;
                    state_n   = S_END;
                end
            end
            S_END: begin
                cnt_n   = '0;
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        case (state_n)
            S_CMD: begin
                cs_n = 1'b1;
                sk_n = (cnt_n >= CNT_W'(SK_DIV));
                di_n = cmd[BIT_W'(CMD_LEN - 1) - bit_n];
            end
            S_DOUT: begin
                cs_n = 1'b1;
                sk_n = (cnt_n >= CNT_W'(SK_DIV));
                di_n = wdata[BIT_W'(15) - bit_n];
            end
            S_DIN: begin
                cs_n = 1'b1;
                sk_n = (cnt_n >= CNT_W'(SK_DIV));
            end
            S_POLL:  cs_n = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (bus.IO_ADDR)
            3'd0:    rdata = rbuf[7:0];
            3'd1:    rdata = rbuf[15:8];
            3'd2:    rdata = cmd[7:0];
            3'd3:    rdata = cmd[15:8];
            3'd4:    rdata = {5'b00000, timeout, idle, done};
            default: rdata = 8'hFF;
        endcase
    end

    assign bus.IO_RDATA = rdata;
    assign bus.EE_CS    = cs;
    assign bus.EE_SK    = sk;
    assign bus.EE_DI    = di;
endmodule

// File: tb/tb_bandai_eeprom_ctrl.sv
// Self-checking bench for bandai_eeprom_ctrl with a behavioural 93C46 x16 model.
module tb_bandai_eeprom_ctrl;
    localparam int unsigned SK_DIV    = 4;
    localparam int unsigned ADDR_BITS = 6;
    localparam int unsigned POLL_MAX  = 1000;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    bandai_eeprom_ctrl_if bus();

    bandai_eeprom_ctrl #(
        .SK_DIV(SK_DIV), .ADDR_BITS(ADDR_BITS), .POLL_MAX(POLL_MAX)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // EEPROM model observation state (written only by the model process)
    int          sk_rises = 0, cs_rises = 0, frame_bit = 0, prev_bits = 0;
    int          hi_cnt = 0, low_cnt = 0, hi_len = 0, low_len = 0, poll_cnt = 0, viol = 0;
    logic [31:0] di_bits = '0;
    logic [8:0]  cmd9 = '0;
    logic        poll_phase = 1'b0, cs_prev = 1'b0, sk_prev = 1'b0;
    logic [15:0] mem [64];
    logic [15:0] w;
    int          mode = 0;  // 0: plain, 1: ready 100 CLK into poll, 2: never ready

    initial begin
        bus.EE_DO = 1'b0;
        foreach (mem[i]) mem[i] = 16'h0000;
        mem[5] = 16'hBEEF;
        forever begin
            @(negedge CLK);
            if (bus.EE_CS && !cs_prev) begin
                cs_rises++;
                if (bus.EE_SK) viol++;
                low_len    = low_cnt;
                poll_phase = (prev_bits > 0) && (cmd9[8:6] == 3'b101 || cmd9[8:6] == 3'b111);
                frame_bit  = 0;
                hi_cnt     = 0;
                poll_cnt   = 0;
            end
            if (!bus.EE_CS && cs_prev) begin
                if (bus.EE_SK) viol++;
                hi_len     = hi_cnt;
                prev_bits  = frame_bit;
                low_cnt    = 0;
                poll_phase = 1'b0;
                bus.EE_DO  = 1'b0;
            end
            if (bus.EE_CS) hi_cnt++; else low_cnt++;
            if (bus.EE_CS && bus.EE_SK && !sk_prev) begin
                sk_rises++;
                di_bits = {di_bits[30:0], bus.EE_DI};
                if (frame_bit == 8) cmd9 = di_bits[8:0];
                if (frame_bit >= 9 && frame_bit <= 24 && cmd9[8:6] == 3'b110) begin
                    w = mem[cmd9[5:0]];
                    bus.EE_DO = w[24 - frame_bit];
                end
                frame_bit++;
            end
            if (poll_phase && bus.EE_CS) begin
                poll_cnt++;
                if (mode == 1 && poll_cnt >= 100) bus.EE_DO = 1'b1;
            end
            cs_prev = bus.EE_CS;
            sk_prev = bus.EE_SK;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic io_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge CLK);
        bus.IO_WE    = 1'b1;
        bus.IO_ADDR  = a;
        bus.IO_WDATA = d;
        @(negedge CLK);
        bus.IO_WE    = 1'b0;
    endtask

    task automatic io_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge CLK);
        bus.IO_ADDR = a;
        #1 d = bus.IO_RDATA;
    endtask

    task automatic wait_ready(input int budget, input string name);
        logic ok;
        ok = 1'b0;
        bus.IO_ADDR = 3'd4;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (bus.IO_RDATA[1]) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic       chk;
        logic [7:0] exp;
    } vec_t;

    vec_t        vecs [18];
    logic [7:0]  rd;
    int          r0, s0;
    logic        ok;

    initial begin
        RST          = 1'b1;
        bus.IO_WE    = 1'b0;
        bus.IO_ADDR  = 3'd0;
        bus.IO_WDATA = 8'h00;

        vecs[0]  = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h00};
        vecs[1]  = '{1'b0, 3'd1, 8'h00, 1'b1, 8'h00};
        vecs[2]  = '{1'b0, 3'd2, 8'h00, 1'b1, 8'h00};
        vecs[3]  = '{1'b0, 3'd3, 8'h00, 1'b1, 8'h00};
        vecs[4]  = '{1'b0, 3'd4, 8'h00, 1'b1, 8'h02};
        vecs[5]  = '{1'b0, 3'd5, 8'h00, 1'b1, 8'hFF};
        vecs[6]  = '{1'b0, 3'd6, 8'h00, 1'b1, 8'hFF};
        vecs[7]  = '{1'b0, 3'd7, 8'h00, 1'b1, 8'hFF};
        vecs[8]  = '{1'b1, 3'd0, 8'h34, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 3'd1, 8'h12, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h00};
        vecs[11] = '{1'b1, 3'd2, 8'h85, 1'b0, 8'h00};
        vecs[12] = '{1'b1, 3'd3, 8'h01, 1'b0, 8'h00};
        vecs[13] = '{1'b0, 3'd2, 8'h00, 1'b1, 8'h85};
        vecs[14] = '{1'b0, 3'd3, 8'h00, 1'b1, 8'h01};
        vecs[15] = '{1'b1, 3'd4, 8'h0F, 1'b0, 8'h00};
        vecs[16] = '{1'b0, 3'd4, 8'h00, 1'b1, 8'h02};
        vecs[17] = '{1'b0, 3'd4, 8'h00, 1'b1, 8'h02};

        #1;
        check("reset_pins", {29'd0, bus.EE_CS, bus.EE_SK, bus.EE_DI}, 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // Register file behaviour while idle
        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            bus.IO_WE    = vecs[i].we;
            bus.IO_ADDR  = vecs[i].addr;
            bus.IO_WDATA = vecs[i].wdata;
            #1;
            if (vecs[i].chk) check($sformatf("vec%0d", i), 32'(bus.IO_RDATA), 32'(vecs[i].exp));
        end
        @(negedge CLK);
        bus.IO_WE = 1'b0;
        check("noop_no_frame", 32'(cs_rises), 32'd0);

        // READ of word 05h
        r0 = cs_rises; s0 = sk_rises;
        io_write(3'd2, 8'h85); io_write(3'd3, 8'h01); io_write(3'd4, 8'h10);
        wait_ready(400, "read_ready");
        check("read_sk_periods", 32'(sk_rises - s0), 32'd25);
        check("read_frames", 32'(cs_rises - r0), 32'd1);
        check("read_frame_len", 32'(hi_len), 32'd200);
        check("read_di", 32'(di_bits[24:0]), 32'({9'b110000101, 16'h0000}));
        io_read(3'd4, rd); check("read_status", 32'(rd), 32'h03);
        io_read(3'd0, rd); check("read_c4", 32'(rd), 32'hEF);
        io_read(3'd1, rd); check("read_c5", 32'(rd), 32'hBE);

        // WRITE 1234h with a 100-cycle busy poll
        mode = 1;
        r0 = cs_rises;
        io_write(3'd0, 8'h34); io_write(3'd1, 8'h12);
        io_write(3'd2, 8'h45); io_write(3'd3, 8'h01); io_write(3'd4, 8'h20);
        wait_ready(800, "write_ready");
        check("write_di", 32'(di_bits[24:0]), 32'({9'b101000101, 16'h1234}));
        check("write_gap_len", 32'(low_len), 32'd8);
        check("write_poll_len", 32'(hi_len), 32'd102);
        check("write_cs_rises", 32'(cs_rises - r0), 32'd2);
        io_read(3'd4, rd); check("write_status", 32'(rd), 32'h03);
        mode = 0;

        // Priority (READ wins) and busy lockout
        r0 = cs_rises;
        io_write(3'd2, 8'h85); io_write(3'd3, 8'h01); io_write(3'd4, 8'h30);
        repeat (30) @(negedge CLK);
        io_write(3'd0, 8'hAA); io_write(3'd2, 8'h00); io_write(3'd4, 8'h20);
        wait_ready(400, "lock_ready");
        check("lock_frames", 32'(cs_rises - r0), 32'd1);
        check("lock_frame_len", 32'(hi_len), 32'd200);
        check("lock_di", 32'(di_bits[24:0]), 32'({9'b110000101, 16'h0000}));
        io_read(3'd0, rd); check("lock_c4", 32'(rd), 32'hEF);
        io_read(3'd2, rd); check("lock_c6", 32'(rd), 32'h85);
        io_read(3'd4, rd); check("lock_status", 32'(rd), 32'h03);

        // ERASE with DO stuck low: poll timeout
        mode = 2;
        io_write(3'd2, 8'hC5); io_write(3'd3, 8'h01); io_write(3'd4, 8'h40);
        wait_ready(1500, "erase_ready");
        check("erase_gap_len", 32'(low_len), 32'd8);
        check("erase_poll_len", 32'(hi_len), 32'd1000);
        check("erase_cs_low", 32'(bus.EE_CS), 32'd0);
        io_read(3'd4, rd); check("timeout_status", 32'(rd), 32'h07);
        mode = 0;

        // SHORT (EWEN) right after: clears TIMEOUT, exact completion time
        r0 = cs_rises; s0 = sk_rises;
        io_write(3'd2, 8'h30); io_write(3'd3, 8'h01); io_write(3'd4, 8'h80);
        #1 check("short_started", 32'(bus.IO_RDATA), 32'h00);
        repeat (72) @(negedge CLK);
        check("short_busy_72", 32'(bus.IO_RDATA), 32'h00);
        @(negedge CLK);
        check("short_done_73", 32'(bus.IO_RDATA), 32'h03);
        check("short_sk_periods", 32'(sk_rises - s0), 32'd9);
        check("short_frame_len", 32'(hi_len), 32'd72);
        check("short_frames", 32'(cs_rises - r0), 32'd1);

        // Asynchronous reset in the middle of DOUT
        io_write(3'd2, 8'h45); io_write(3'd3, 8'h01); io_write(3'd4, 8'h20);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (frame_bit >= 23) begin
                ok = 1'b1;
                break;
            end
        end
        check("dout_reached", 32'(ok), 32'd1);
        check("dout_partial_di", 32'(di_bits[22:0]), 32'({9'b101000101, 14'b00010010001101}));
        @(negedge CLK);
        #2 RST = 1'b1;
        #1 check("async_rst_pins", {29'd0, bus.EE_CS, bus.EE_SK, bus.EE_DI}, 32'd0);
        io_read(3'd0, rd); check("rst_c4", 32'(rd), 32'h00);
        io_read(3'd1, rd); check("rst_c5", 32'(rd), 32'h00);
        io_read(3'd2, rd); check("rst_c6", 32'(rd), 32'h00);
        io_read(3'd3, rd); check("rst_c7", 32'(rd), 32'h00);
        io_read(3'd4, rd); check("rst_status", 32'(rd), 32'h02);
        @(negedge CLK);
        RST = 1'b0;

        // Fresh READ after reset
        io_write(3'd2, 8'h85); io_write(3'd3, 8'h01); io_write(3'd4, 8'h10);
        wait_ready(400, "post_rst_ready");
        io_read(3'd0, rd); check("post_rst_c4", 32'(rd), 32'hEF);
        io_read(3'd1, rd); check("post_rst_c5", 32'(rd), 32'hBE);
        io_read(3'd4, rd); check("post_rst_status", 32'(rd), 32'h03);
        check("sk_low_at_cs_edges", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
